// File: rtl/sprite_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_renderer_pkg
// Description : Shared types and constants for the sprite renderer: FSM
//               state encoding, LCD geometry, RGB565 colours and an
//               on-screen test helper.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_renderer_pkg;

   // Render pass phases
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ERASE  = 3'd1,
      ST_FETCH  = 3'd2,
      ST_WAIT   = 3'd3,
      ST_DRAW   = 3'd4,
      ST_FINISH = 3'd5
   } state_t;

   localparam int LCD_WIDTH  = 240;
   localparam int LCD_HEIGHT = 320;

   localparam logic [15:0] RGB565_BLACK   = 16'h0000;
   localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
   localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;

   // Coordinates arrive one bit wider than the LCD range so that an origin
   // near the right/bottom edge plus the raster offset cannot alias back
   // onto the screen.
   function automatic logic in_lcd(input logic [8:0] sx, input logic [9:0] sy);
      return (sx < 9'(LCD_WIDTH)) && (sy < 10'(LCD_HEIGHT));
   endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_renderer_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_renderer_if
// Description : Bundles the pass request, sprite ROM port and LCD pixel
//               write handshake. "master" is the host/ROM/LCD side,
//               "slave" is the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_renderer_if #(
   parameter int SPRITE_W = 32,
   parameter int SPRITE_H = 32
);
   localparam int ROM_AW = 4 + $clog2(SPRITE_W * SPRITE_H);

   logic              frame_start;
   logic [7:0]        x_sprite;
   logic [8:0]        y_sprite;
   logic [3:0]        sprite_id;
   logic [ROM_AW-1:0] rom_addr;
   logic [15:0]       rom_data;
   logic [7:0]        pixel_x;
   logic [8:0]        pixel_y;
   logic [15:0]       pixel_data;
   logic              pixel_valid;
   logic              pixel_ready;
   logic              busy;
   logic              done;

   modport master (
      output frame_start, x_sprite, y_sprite, sprite_id, rom_data, pixel_ready,
      input  rom_addr, pixel_x, pixel_y, pixel_data, pixel_valid, busy, done
   );

   modport slave (
      input  frame_start, x_sprite, y_sprite, sprite_id, rom_data, pixel_ready,
      output rom_addr, pixel_x, pixel_y, pixel_data, pixel_valid, busy, done
   );

endinterface
`default_nettype wire

// File: rtl/sprite_renderer_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : sprite_raster_counter
// Description : Row-major column/row walker over a COLS x ROWS box. Column
//               runs fastest; the counter parks on the final cell and flags
//               it instead of wrapping back to the first row.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_raster_counter #(
   parameter int COLS = 32,
   parameter int ROWS = 32
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     i_clear,
   input  logic                     i_advance,
   output logic [$clog2(COLS)-1:0]  o_col,
   output logic [$clog2(ROWS)-1:0]  o_row,
   output logic                     o_last
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] c_COL_MAX = CW'(COLS - 1);
   localparam logic [RW-1:0] c_ROW_MAX = RW'(ROWS - 1);

   logic [CW-1:0] r_col;
   logic [RW-1:0] r_row;

   // Step through the box; clear has priority, the last cell holds
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_clear) begin
         r_col <= '0;
         r_row <= '0;
      end else if (i_advance && !o_last) begin
         if (r_col == c_COL_MAX) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   assign o_col  = r_col;
   assign o_row  = r_row;
   assign o_last = (r_col == c_COL_MAX) && (r_row == c_ROW_MAX);

endmodule
`default_nettype wire

// File: rtl/sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : sprite_renderer
// Description : Renders one sprite per frame_start pulse. Erases the box drawn
//               by the previous pass with BG_COLOUR, then fetches each texel
//               from the sprite ROM and writes it to the LCD. Off-screen
//               pixels are skipped.
//               Build option: define SPRITE_TRANSPARENCY_EN to also skip
//               draw pixels whose texel equals KEY_COLOUR.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_renderer
   import sprite_renderer_pkg::*;
#(
   parameter int          SPRITE_W   = 32,
   parameter int          SPRITE_H   = 32,
   parameter logic [15:0] BG_COLOUR  = RGB565_BLACK,
   parameter logic [15:0] KEY_COLOUR = RGB565_MAGENTA
) (
   input  logic             clock,
   input  logic             reset,
   sprite_renderer_if.slave bus
);
   localparam int CW = $clog2(SPRITE_W);
   localparam int RW = $clog2(SPRITE_H);

`ifdef SPRITE_TRANSPARENCY_EN
   localparam bit c_TRANSPARENCY = 1'b1;
`else
   localparam bit c_TRANSPARENCY = 1'b0;
`endif

   state_t        r_state;
   logic [7:0]    r_x;
   logic [8:0]    r_y;
   logic [3:0]    r_id;
   logic [7:0]    r_prev_x;
   logic [8:0]    r_prev_y;
   logic          r_prev_valid;
   logic [15:0]   r_texel;
   logic          r_pixel_valid;
   logic [7:0]    r_pixel_x;
   logic [8:0]    r_pixel_y;
   logic [15:0]   r_pixel_data;
   logic          r_busy;
   logic          r_done;

   logic [CW-1:0] w_col;
   logic [RW-1:0] w_row;
   logic          w_last;
   logic          w_slot_free;
   logic          w_clear;
   logic          w_advance;
   logic [7:0]    w_org_x;
   logic [8:0]    w_org_y;
   logic [8:0]    w_sum_x;
   logic [9:0]    w_sum_y;
   logic          w_in_bounds;
   logic          w_emit;

   // The output slot can take a new pixel when empty or being accepted now
   assign w_slot_free = !r_pixel_valid || bus.pixel_ready;

   // One raster walker shared by the erase and draw phases; it restarts at
   // pass acceptance and again at the erase-to-draw hand-over.
   assign w_clear   = ((r_state == ST_IDLE)  && bus.frame_start) ||
                      ((r_state == ST_ERASE) && w_slot_free && w_last);
   assign w_advance = ((r_state == ST_ERASE) || (r_state == ST_DRAW)) && w_slot_free;

   sprite_raster_counter #(
      .COLS (SPRITE_W),
      .ROWS (SPRITE_H)
   ) u_raster (
      .clock     (clock),
      .reset     (reset),
      .i_clear   (w_clear),
      .i_advance (w_advance),
      .o_col     (w_col),
      .o_row     (w_row),
      .o_last    (w_last)
   );

   // Erase walks the previous box, draw walks the latched origin
   assign w_org_x     = (r_state == ST_ERASE) ? r_prev_x : r_x;
   assign w_org_y     = (r_state == ST_ERASE) ? r_prev_y : r_y;
   assign w_sum_x     = {1'b0, w_org_x} + 9'(w_col);
   assign w_sum_y     = {1'b0, w_org_y} + 10'(w_row);
   assign w_in_bounds = in_lcd(w_sum_x, w_sum_y);
   assign w_emit      = w_in_bounds && !(c_TRANSPARENCY && (r_texel == KEY_COLOUR));

   // Main pass sequencer with registered outputs
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_x           <= '0;
         r_y           <= '0;
         r_id          <= '0;
         r_prev_x      <= '0;
         r_prev_y      <= '0;
         r_prev_valid  <= 1'b0;
         r_texel       <= '0;
         r_pixel_valid <= 1'b0;
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_pixel_data  <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_pixel_valid && bus.pixel_ready) begin
            r_pixel_valid <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.frame_start) begin
                  r_x     <= bus.x_sprite;
                  r_y     <= bus.y_sprite;
                  r_id    <= bus.sprite_id;
                  r_busy  <= 1'b1;
                  r_state <= r_prev_valid ? ST_ERASE : ST_FETCH;
               end
            end
            ST_ERASE: begin
               if (w_slot_free) begin
                  r_pixel_valid <= w_in_bounds;
                  if (w_in_bounds) begin
                     r_pixel_x    <= w_sum_x[7:0];
                     r_pixel_y    <= w_sum_y[8:0];
                     r_pixel_data <= BG_COLOUR;
                  end
                  if (w_last) begin
                     r_state <= ST_FETCH;
                  end
               end
            end
            ST_FETCH: begin
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               r_texel <= bus.rom_data;
               r_state <= ST_DRAW;
            end
            ST_DRAW: begin
               if (w_slot_free) begin
                  r_pixel_valid <= w_emit;
                  if (w_emit) begin
                     r_pixel_x    <= w_sum_x[7:0];
                     r_pixel_y    <= w_sum_y[8:0];
                     r_pixel_data <= r_texel;
                  end
                  r_state <= w_last ? ST_FINISH : ST_FETCH;
               end
            end
            ST_FINISH: begin
               // Hold off completion until the final write has been taken
               if (w_slot_free) begin
                  r_done       <= 1'b1;
                  r_busy       <= 1'b0;
                  r_prev_x     <= r_x;
                  r_prev_y     <= r_y;
                  r_prev_valid <= 1'b1;
                  r_state      <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rom_addr    = {r_id, w_row, w_col};
   assign bus.pixel_valid = r_pixel_valid;
   assign bus.pixel_x     = r_pixel_x;
   assign bus.pixel_y     = r_pixel_y;
   assign bus.pixel_data  = r_pixel_data;
   assign bus.busy        = r_busy;
   assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_sprite_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_renderer
// Description : Directed bench for sprite_renderer. Expected LCD writes are
//               queued when a pass is requested and popped as the DUT's
//               handshakes complete.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sprite_renderer;
   import sprite_renderer_pkg::*;

   localparam int          SW  = 32;
   localparam int          SH  = 32;
   localparam logic [15:0] BG  = 16'h0000;
   localparam logic [15:0] KEY = 16'hF81F;

   typedef struct packed {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] d;
   } wr_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sprite_renderer_if #(.SPRITE_W(SW), .SPRITE_H(SH)) bus ();

   sprite_renderer #(
      .SPRITE_W   (SW),
      .SPRITE_H   (SH),
      .BG_COLOUR  (BG),
      .KEY_COLOUR (KEY)
   ) dut (
      .clock (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   wr_t        exp_q[$];
   int         n_checks = 0;
   int         n_errors = 0;
   int         n_writes = 0;
   int         n_done   = 0;
   int         exp_cnt  = 0;
   wr_t        first_wr;
   wr_t        last_wr;
   bit         key_mode   = 1'b0;
   bit         rand_ready = 1'b0;
   bit         have_prev  = 1'b0;
   int         prev_x     = 0;
   int         prev_y     = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sprite ROM contents: a per-address pattern, or a keyed frame where only
   // one word (id 4, row 0, col 5) is opaque.
   function automatic logic [15:0] rom_fn(input logic [13:0] a, input bit km);
      if (km) return (a == 14'h1005) ? 16'h1234 : KEY;
      return {2'b10, a} ^ 16'h5A5A;
   endfunction

   always @(posedge clk) bus.rom_data <= rom_fn(bus.rom_addr, key_mode);

   // Sink readiness: always ready, or a coin toss each cycle
   initial begin
      bus.pixel_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.pixel_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Handshake monitor: scoreboard pop plus hold-while-stalled check
   always @(negedge clk) begin : mon
      wr_t cur;
      static bit  hold_pend = 1'b0;
      static wr_t hold_val  = '0;
      cur = {bus.pixel_x, bus.pixel_y, bus.pixel_data};
      if (reset) begin
         hold_pend = 1'b0;
      end else begin
         if (hold_pend) begin
            chk("hold_valid", bus.pixel_valid, 1);
            chk("hold_payload", cur, hold_val);
         end
         if (bus.done) n_done++;
         if (bus.pixel_valid && bus.pixel_ready) begin
            n_writes++;
            if (n_writes == 1) first_wr = cur;
            last_wr = cur;
            if (exp_q.size() == 0) chk("write_expected", 0, 1);
            else                   chk("write", cur, exp_q.pop_front());
         end
         hold_pend = bus.pixel_valid && !bus.pixel_ready;
         hold_val  = cur;
      end
   end

   // Queue every write the pass should produce, in order
   task automatic build_expect(input int x, input int y, input logic [3:0] id);
      logic [13:0] a;
      logic [15:0] d;
      bit          emit;
      exp_cnt = 0;
      if (have_prev) begin
         for (int r = 0; r < SH; r++) begin
            for (int c = 0; c < SW; c++) begin
               if (prev_x + c < 240 && prev_y + r < 320) begin
                  exp_q.push_back({8'(prev_x + c), 9'(prev_y + r), BG});
                  exp_cnt++;
               end
            end
         end
      end
      for (int r = 0; r < SH; r++) begin
         for (int c = 0; c < SW; c++) begin
            a    = {id, 5'(r), 5'(c)};
            d    = rom_fn(a, key_mode);
            emit = (x + c < 240) && (y + r < 320);
`ifdef SPRITE_TRANSPARENCY_EN
            if (d == KEY) emit = 1'b0;
`endif
            if (emit) begin
               exp_q.push_back({8'(x + c), 9'(y + r), d});
               exp_cnt++;
            end
         end
      end
      have_prev = 1'b1;
      prev_x    = x;
      prev_y    = y;
   endtask

   // One pass, including an ignored retrigger with different inputs mid-pass
   task automatic run_pass(input logic [7:0] x, input logic [8:0] y,
                           input logic [3:0] id, input int exp_cycles);
      int cyc;
      bit seen;
      build_expect(int'(x), int'(y), id);
      @(negedge clk);
      n_writes = 0;
      n_done   = 0;
      bus.frame_start = 1'b1;
      bus.x_sprite    = x;
      bus.y_sprite    = y;
      bus.sprite_id   = id;
      seen = 1'b0;
      cyc  = 0;
      for (int i = 1; i <= 40000; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.frame_start = 1'b0;
            chk("busy_after_start", bus.busy, 1);
         end
         if (i == 2) begin
            bus.frame_start = 1'b1;
            bus.x_sprite    = ~x;
            bus.y_sprite    = y ^ 9'h0AA;
            bus.sprite_id   = ~id;
         end
         if (i == 3) bus.frame_start = 1'b0;
         if (bus.done) begin
            seen = 1'b1;
            cyc  = i;
            break;
         end
      end
      chk("done_seen", seen, 1);
      chk("busy_at_done", bus.busy, 0);
      if (exp_cycles > 0) chk("pass_cycles", cyc, exp_cycles);
      repeat (3) @(negedge clk);
      chk("done_pulses", n_done, 1);
      chk("write_count", n_writes, exp_cnt);
      chk("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      bus.frame_start = 1'b0;
      bus.x_sprite    = '0;
      bus.y_sprite    = '0;
      bus.sprite_id   = '0;
      reset           = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_valid", bus.pixel_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_rom_addr", bus.rom_addr, 0);
      chk("rst_pixel_x", bus.pixel_x, 0);
      chk("rst_pixel_y", bus.pixel_y, 0);
      chk("rst_pixel_data", bus.pixel_data, 0);
      reset = 1'b0;

      // First pass: no erase, 3 cycles per draw pixel plus entry and finish
      run_pass(8'd95, 9'd119, 4'd0, 1 + 3 * 1024 + 1);
      chk("p1_writes", n_writes, 1024);
      chk("p1_first_x", first_wr.x, 95);
      chk("p1_first_y", first_wr.y, 119);
      chk("p1_last_x", last_wr.x, 126);
      chk("p1_last_y", last_wr.y, 150);

      // Second pass: full erase at one pixel per cycle, then draw from id 1
      run_pass(8'd109, 9'd119, 4'd1, 1024 + 1 + 3 * 1024 + 1);
      chk("p2_writes", n_writes, 2048);
      chk("p2_first", first_wr, {8'd95, 9'd119, BG});
      chk("p2_last_data", last_wr.d, rom_fn(14'h07FF, 1'b0));

      // Clipped corner sprite: only 10x10 visible
      run_pass(8'd230, 9'd310, 4'd2, -1);
      chk("p3_writes", n_writes, 1024 + 100);

      // Back-pressure from the sink
      rand_ready = 1'b1;
      run_pass(8'd50, 9'd60, 4'd3, -1);
      rand_ready = 1'b0;
      chk("p4_writes", n_writes, 100 + 1024);

      // Keyed sprite frame
      key_mode = 1'b1;
      run_pass(8'd0, 9'd0, 4'd4, -1);
      key_mode = 1'b0;
`ifdef SPRITE_TRANSPARENCY_EN
      chk("p5_writes", n_writes, 1024 + 1);
`else
      chk("p5_writes", n_writes, 1024 + 1024);
`endif

      // Reset in the middle of an erase
      build_expect(10, 10, 4'd0);
      @(negedge clk);
      bus.frame_start = 1'b1;
      bus.x_sprite    = 8'd10;
      bus.y_sprite    = 9'd10;
      bus.sprite_id   = 4'd0;
      @(negedge clk);
      bus.frame_start = 1'b0;
      repeat (40) @(negedge clk);
      chk("mid_erase_busy", bus.busy, 1);
      chk("mid_erase_valid", bus.pixel_valid, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", bus.pixel_valid, 0);
      chk("rst_mid_busy", bus.busy, 0);
      exp_q.delete();
      have_prev = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // After reset there is no previous box to erase
      run_pass(8'd20, 9'd20, 4'd5, 1 + 3 * 1024 + 1);
      chk("p7_writes", n_writes, 1024);
      chk("p7_first", first_wr, {8'd20, 9'd20, rom_fn(14'h1400, 1'b0)});

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sprite_renderer.md
SPRITE_RENDERER -- requirements
Module: sprite_renderer

Interface
REQ-001 Parameter SPRITE_W, 32, sprite width in pixels (power of two).
REQ-002 Parameter SPRITE_H, 32, sprite height in pixels (power of two).
REQ-003 Parameter BG_COLOUR, 16'h0000, RGB565 colour written when erasing.
REQ-004 Parameter KEY_COLOUR, 16'hF81F, RGB565 transparent key colour.
REQ-005 clock  in  1  system clock; all state changes on rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-high.
REQ-007 frame_start  in  1  single-cycle pulse requesting one render pass.
REQ-008 x_sprite  in  8  sprite origin column (top-left), LCD space 0..239.
REQ-009 y_sprite  in  9  sprite origin row (top-left), LCD space 0..319.
REQ-010 sprite_id  in  4  sprite frame index into ROM.
REQ-011 rom_addr  out  4+log2(SPRITE_W*SPRITE_H)  sprite ROM address.
REQ-012 rom_data  in  16  RGB565 ROM word, valid exactly 1 cycle after rom_addr.
REQ-013 pixel_x / pixel_y  out  8 / 9  LCD write coordinate.
REQ-014 pixel_data  out  16  RGB565 write colour.
REQ-015 pixel_valid  out  1  write request; pixel_ready  in  1  sink accepts when both high.
REQ-016 busy  out  1  high from pass acceptance until done; done  out  1  one-cycle end-of-pass pulse.

Function
REQ-017 States SHALL be IDLE, ERASE, FETCH, WAIT, DRAW, FINISH.
REQ-018 In IDLE, frame_start SHALL latch x_sprite, y_sprite, sprite_id into working registers and move to ERASE (or FETCH if no previous pass since reset); busy rises next cycle.
REQ-019 frame_start while busy SHALL be ignored; no queuing.
REQ-020 ERASE SHALL emit BG_COLOUR over the previous pass's SPRITE_W x SPRITE_H box, row-major, column fastest, one pixel per accepted handshake.
REQ-021 FETCH SHALL drive rom_addr = {sprite_id, row, col}; WAIT SHALL capture rom_data next cycle; DRAW SHALL present the pixel at (x+col, y+row).
REQ-022 pixel_valid high SHALL hold pixel_x, pixel_y, pixel_data stable until pixel_ready is sampled high.
REQ-023 Coordinate sums SHALL be computed one bit wider; pixels with x>239 or y>319 SHALL be skipped (no pixel_valid) and counters advance.
REQ-024 After last pixel (col=SPRITE_W-1, row=SPRITE_H-1) accepted or skipped, FINISH SHALL pulse done for one cycle, store latched origin as previous box, return to IDLE.
REQ-025 Counters SHALL wrap col to 0 and increment row at col=SPRITE_W-1; no wrap beyond last row.
REQ-026 Maximum throughput SHALL be one erase pixel per cycle and one draw pixel per 3 cycles with pixel_ready held high.
REQ-027 Inputs x_sprite/y_sprite/sprite_id changing mid-pass SHALL not affect the pass.

Reset
REQ-028 Reset SHALL force IDLE, pixel_valid=0, busy=0, done=0, rom_addr=0, pixel_x=0, pixel_y=0, pixel_data=0, counters=0, previous-box-valid=0, mid-pass included; no partial pixel completed.

Configuration
REQ-029 Macro SPRITE_TRANSPARENCY_EN defined: draw pixels whose rom_data equals KEY_COLOUR SHALL be skipped as in REQ-023.
REQ-030 Macro undefined: every in-bounds draw pixel SHALL be emitted, KEY_COLOUR included; erase unaffected.

Structure
REQ-031 Shared package SHALL hold state encodings, LCD_WIDTH=240, LCD_HEIGHT=320, and RGB565 colour constants.
REQ-032 One sub-module sprite_raster_counter (col/row counter with wrap and last flag) SHALL be reused by ERASE and draw phases.

Verification
REQ-033 Reset, frame_start at (95,119), id 0, ready=1 -> 1024 writes, no erase, first write (95,119), last (126,150), done once.
REQ-034 Second pass at (109,119) -> 1024 BG writes over (95..126,119..150), then 1024 draw writes, ROM base id*1024.
REQ-035 Origin (230,310) -> only 10x10=100 draw writes emitted, done still pulses.
REQ-036 pixel_ready toggled randomly -> outputs stable while valid&!ready, write count unchanged.
REQ-037 With SPRITE_TRANSPARENCY_EN, ROM of all 16'hF81F except one word -> exactly one draw write; without macro -> 1024.
REQ-038 reset asserted mid-ERASE -> pixel_valid and busy low same cycle; next frame_start performs no erase.
